// File: rtl/mmio_wsel_pkg.sv
// Shared address-map constants and region decode for the store path (mmio_wsel)
// and the load-side read select.
package mmio_wsel_pkg;

  localparam logic [3:0] REG_DMEM = 4'b0001;
  localparam logic [3:0] REG_IMEM = 4'b0010;
  localparam logic [3:0] REG_BOTH = 4'b0011;
  localparam logic [3:0] REG_BIOS = 4'b0100;
  localparam logic [3:0] REG_MMIO = 4'b1000;

  localparam logic [7:0] MMIO_STATUS = 8'h00;
  localparam logic [7:0] MMIO_RX     = 8'h04;
  localparam logic [7:0] MMIO_TX     = 8'h08;
  localparam logic [7:0] MMIO_CTRL   = 8'h18;

  typedef struct packed {
    logic dmem;
    logic imem;
    logic mmio;
  } region_sel_t;

  function automatic region_sel_t decode_region(input logic [3:0] region);
    region_sel_t sel;
    sel = '0;
    case (region)
      REG_DMEM: sel.dmem = 1'b1;
      REG_IMEM: sel.imem = 1'b1;
      REG_BOTH: begin
        sel.dmem = 1'b1;
        sel.imem = 1'b1;
      end
      REG_MMIO: sel.mmio = 1'b1;
      // BIOS is read-only; it and every unmapped region drop the store.
      REG_BIOS: sel = '0;
      default:  sel = '0;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/mmio_wsel_tx_fifo.sv
// Generic synchronous FIFO with registered pointers and occupancy count.
// A push while full is dropped, and full is judged before any same-cycle pop.
module tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == FULL_COUNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointers are exactly AW bits wide, so the increment wraps modulo DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage has no reset; the count alone decides which entries are
  // valid, and leaving the array unreset keeps it a plain register file.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/mmio_wsel.sv
// Store-side address decode: byte write enables for DMEM/IMEM, UART TX byte
// capture into a FIFO, and the sticky TX overflow flag.
module mmio_wsel
  import mmio_wsel_pkg::*;
#(
  parameter int TX_DEPTH = 4,
  parameter int TX_AW    = $clog2(TX_DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  input  logic [3:0]  wmask,
  output logic [3:0]  dmem_wea,
  output logic [31:0] dmem_dina,
  output logic [3:0]  imem_wea,
  output logic [31:0] imem_dina,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        trmt_full,
  output logic        tx_overflow
);

  region_sel_t    sel;
  logic           tx_store, ctrl_store;
  logic           fifo_full, fifo_empty;
  logic [TX_AW:0] fifo_count;
  logic           tx_overflow_q, tx_overflow_d;
  logic           unused_ok;

  assign sel = decode_region(addr[31:28]);

  // Write enables are gated by rst_n so no memory write can slip through
  // while the core is held in reset.
  assign dmem_wea  = (rst_n && sel.dmem) ? wmask : 4'b0;
  assign imem_wea  = (rst_n && sel.imem) ? wmask : 4'b0;
  assign dmem_dina = din;
  assign imem_dina = din;

  assign tx_store   = sel.mmio && (addr[7:0] == MMIO_TX) && wmask[0];
  assign ctrl_store = sel.mmio && (addr[7:0] == MMIO_CTRL) && (wmask != 4'b0);

  tx_fifo #(
    .DEPTH (TX_DEPTH),
    .WIDTH (8),
    .AW    (TX_AW)
  ) u_tx_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (tx_store),
    .wdata_i (din[7:0]),
    .pop_i   (tx_valid && tx_ready),
    .rdata_o (tx_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign tx_valid  = !fifo_empty;
  assign trmt_full = fifo_full;

  always_comb begin
    tx_overflow_d = tx_overflow_q;
    if (ctrl_store)             tx_overflow_d = 1'b0;
    if (tx_store && fifo_full)  tx_overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tx_overflow_q <= 1'b0;
    else        tx_overflow_q <= tx_overflow_d;
  end

  assign tx_overflow = tx_overflow_q;

  // Offset-only MMIO decode leaves the middle address bits unused.
  assign unused_ok = ^{addr[27:8], fifo_count};

endmodule

// File: tb/tb_mmio_wsel.sv
// Self-checking bench for mmio_wsel: decode vector table plus a TX scoreboard
// that models FIFO contents and the overflow flag cycle by cycle.
module tb_mmio_wsel;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr, din;
  logic [3:0]  wmask;
  logic [3:0]  dmem_wea, imem_wea;
  logic [31:0] dmem_dina, imem_dina;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready, trmt_full, tx_overflow;

  always #5 clk = ~clk;

  mmio_wsel dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .addr        (addr),
    .din         (din),
    .wmask       (wmask),
    .dmem_wea    (dmem_wea),
    .dmem_dina   (dmem_dina),
    .imem_wea    (imem_wea),
    .imem_dina   (imem_dina),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .trmt_full   (trmt_full),
    .tx_overflow (tx_overflow)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic       ovf_m = 1'b0;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [31:0] din;
    logic [3:0]  wmask;
    logic [3:0]  dwea;
    logic [3:0]  iwea;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: drive at negedge, check mid-cycle, then advance the model to
  // what the DUT will hold after the following posedge.
  task automatic cycle(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                       input logic rdy, input string tag);
    logic tx_st, ctl_st, full_m, pop_m;
    @(negedge clk);
    addr = a; din = d; wmask = m; tx_ready = rdy;
    #1;
    check({tag, " tx_valid"},    tx_valid,    exp_q.size() != 0);
    check({tag, " trmt_full"},   trmt_full,   exp_q.size() == 4);
    check({tag, " tx_overflow"}, tx_overflow, ovf_m);
    if (exp_q.size() != 0) check({tag, " tx_data"}, tx_data, exp_q[0]);
    tx_st  = (a[31:28] == 4'h8) && (a[7:0] == 8'h08) && m[0];
    ctl_st = (a[31:28] == 4'h8) && (a[7:0] == 8'h18) && (m != 4'b0);
    full_m = (exp_q.size() == 4);
    pop_m  = (exp_q.size() != 0) && rdy;
    if (tx_st && full_m) ovf_m = 1'b1;
    else if (ctl_st)     ovf_m = 1'b0;
    if (pop_m) void'(exp_q.pop_front());
    if (tx_st && !full_m) exp_q.push_back(d[7:0]);
  endtask

  task automatic idle(input logic rdy, input string tag);
    cycle(32'h0, 32'h0, 4'b0, rdy, tag);
  endtask

  task automatic tx_push(input logic [7:0] b, input logic rdy, input string tag);
    cycle(32'h8000_0008, {24'hDEAD_BE, b}, 4'b0001, rdy, tag);
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{"dmem",       32'h1000_0004, 32'hAABB_CCDD, 4'b0011, 4'b0011, 4'b0000};
    vecs[1] = '{"both",       32'h3000_0004, 32'hAABB_CCDD, 4'b0011, 4'b0011, 4'b0011};
    vecs[2] = '{"bios",       32'h4000_0000, 32'hAABB_CCDD, 4'b0011, 4'b0000, 4'b0000};
    vecs[3] = '{"imem",       32'h2000_0010, 32'h1234_5678, 4'b1111, 4'b0000, 4'b1111};
    vecs[4] = '{"mmio_rx",    32'h8000_0004, 32'h1234_5678, 4'b1111, 4'b0000, 4'b0000};
    vecs[5] = '{"unmapped",   32'hF000_0000, 32'h0000_00FF, 4'b1000, 4'b0000, 4'b0000};
    vecs[6] = '{"no_mask",    32'h1000_0000, 32'h5555_AAAA, 4'b0000, 4'b0000, 4'b0000};
    vecs[7] = '{"tx_no_lane", 32'h8000_0008, 32'h0000_0077, 4'b0010, 4'b0000, 4'b0000};

    rst_n = 1'b0; addr = 32'h1000_0000; din = 32'h0; wmask = 4'b1111; tx_ready = 1'b0;
    #2;
    check("reset dmem_wea", dmem_wea, 4'b0);
    check("reset imem_wea", imem_wea, 4'b0);
    check("reset tx_valid", tx_valid, 1'b0);
    check("reset trmt_full", trmt_full, 1'b0);
    check("reset tx_overflow", tx_overflow, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      cycle(vecs[i].addr, vecs[i].din, vecs[i].wmask, 1'b0, vecs[i].name);
      check({vecs[i].name, " dmem_wea"},  dmem_wea,  vecs[i].dwea);
      check({vecs[i].name, " imem_wea"},  imem_wea,  vecs[i].iwea);
      check({vecs[i].name, " dmem_dina"}, dmem_dina, vecs[i].din);
      check({vecs[i].name, " imem_dina"}, imem_dina, vecs[i].din);
    end

    // First-byte latency and a single-cycle pop.
    tx_push(8'h41, 1'b0, "push41");
    idle(1'b1, "pop41");
    idle(1'b0, "after_pop41");
    check("single pop empties", tx_valid, 1'b0);

    // Fill, overflow, drain in order.
    for (int i = 1; i <= 4; i++) tx_push(8'(i), 1'b0, "fill");
    tx_push(8'h05, 1'b0, "push_when_full");
    check("full_after_4", trmt_full, 1'b1);
    for (int i = 0; i < 5; i++) idle(1'b1, "drain");
    check("ovf held after drain", tx_overflow, 1'b1);

    // Push while full in the same cycle as a pop: pop wins, byte dropped.
    cycle(32'h8000_0018, 32'h0, 4'b0100, 1'b0, "clear_ovf");
    for (int i = 0; i < 4; i++) tx_push(8'h20 + 8'(i), 1'b0, "refill");
    tx_push(8'h09, 1'b1, "push_pop_full");
    idle(1'b0, "after_push_pop");
    check("count 3 not full", trmt_full, 1'b0);
    check("ovf set by push_pop", tx_overflow, 1'b1);
    for (int i = 0; i < 3; i++) idle(1'b1, "drain2");
    cycle(32'h8abc_de18, 32'hFFFF_FFFF, 4'b1000, 1'b0, "clear_ovf2");
    idle(1'b0, "after_clear");
    check("ovf cleared", tx_overflow, 1'b0);

    // Interleaved pushes and pops carry both pointers past the wrap point.
    for (int i = 0; i < 6; i++) tx_push(8'h60 + 8'(i), i[0], "wrap");
    for (int i = 0; i < 5; i++) idle(1'b1, "wrap_drain");
    check("wrap drained", tx_valid, 1'b0);

    // Asynchronous reset mid-cycle with three bytes queued and overflow set.
    for (int i = 0; i < 5; i++) tx_push(8'hA0 + 8'(i), 1'b0, "pre_rst");
    idle(1'b1, "pre_rst_pop");
    idle(1'b0, "pre_rst_hold");
    check("pre_rst three queued", trmt_full, 1'b0);
    check("pre_rst valid", tx_valid, 1'b1);
    #2;
    rst_n = 1'b0; addr = 32'h1000_0000; wmask = 4'b1111;
    #1;
    check("async tx_valid", tx_valid, 1'b0);
    check("async trmt_full", trmt_full, 1'b0);
    check("async tx_overflow", tx_overflow, 1'b0);
    check("async dmem_wea", dmem_wea, 4'b0);
    exp_q.delete();
    ovf_m = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(1'b1, "post_rst");
    idle(1'b1, "post_rst2");
    tx_push(8'h5A, 1'b0, "post_rst_push");
    idle(1'b1, "post_rst_pop");
    idle(1'b0, "post_rst_end");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
